spi_slave_responder: RTL and testbench

- SPI responder (slave) for the far end of the FPGA SPI master link on GPIO_0.
- Lets an FPGA-side endpoint (test fixture, loopback node, or emulated motor board) answer the master's frames.
- Mode 0 (CPOL=0, CPHA=0), MSB first, fixed word width, multiple words per SS_n-low frame.
- SPI pins are oversampled in the system clock domain; the block exposes a TX valid/ready handshake and an RX valid pulse.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/sync_edge_detect.sv | 31 +++
 rtl/spi_slave_responder.sv | 153 +++++++++++++++
 tb/tb_spi_slave_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI link definitions, used by both the responder and the master-side wrapper.
package spi_pkg;

   localparam int SPI_DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      SPI_MODE0 = 2'b00,  // CPOL=0, CPHA=0
      SPI_MODE1 = 2'b01,
      SPI_MODE2 = 2'b10,
      SPI_MODE3 = 2'b11
   } spi_mode_e;

   localparam spi_mode_e SPI_LINK_MODE = SPI_MODE0;

   typedef logic [SPI_DATA_WIDTH-1:0] spi_word_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for one async pin, with rise/fall strobes on the synchronised level.
module sync_edge_detect #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              dly;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= {STAGES{RST_VAL}};
         dly   <= RST_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], d};
         dly   <= chain[STAGES-1];
      end
   end

   assign q    = chain[STAGES-1];
   assign rise = chain[STAGES-1] & ~dly;
   assign fall = ~chain[STAGES-1] & dly;

endmodule

// File: rtl/spi_slave_responder.sv
// Mode-0 SPI responder: oversampled pins, one-entry TX holding buffer, RX word strobe.
module spi_slave_responder
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  spi_sclk,
   input  logic                  spi_mosi,
   input  logic                  spi_ss_n,
   output logic                  spi_miso,
   output logic                  spi_miso_oe,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  tx_underrun,
   output logic                  frame_abort,
   output logic                  busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   logic sclk_lvl_unused, sclk_rise, sclk_fall;
   logic ss_s, ss_rise, ss_fall;
   logic [SYNC_STAGES-1:0] mosi_chain;
   logic mosi_s;

   sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
      .clk (clk), .rst_n (rst_n), .d (spi_sclk),
      .q (sclk_lvl_unused), .rise (sclk_rise), .fall (sclk_fall)
   );

   sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
      .clk (clk), .rst_n (rst_n), .d (spi_ss_n),
      .q (ss_s), .rise (ss_rise), .fall (ss_fall)
   );

   // Same depth as the sclk chain so sampled data lines up with the detected edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mosi_chain <= '0;
      else        mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], spi_mosi};
   end
   assign mosi_s = mosi_chain[SYNC_STAGES-1];

   spi_state_e state_q, state_d;
   logic do_load, do_shift, do_rx, do_end;
   logic pending_load;
   logic [CNT_W-1:0] bit_cnt;
   logic [DATA_WIDTH-2:0] rx_shift;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic [DATA_WIDTH-1:0] buf_data;
   logic buf_full, accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // ss_n edges win over any sclk edge seen in the same cycle.
   always_comb begin
      state_d  = state_q;
      do_load  = 1'b0;
      do_shift = 1'b0;
      do_rx    = 1'b0;
      do_end   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ss_fall) begin
               state_d = ST_ACTIVE;
               do_load = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (ss_rise) begin
               state_d = ST_IDLE;
               do_end  = 1'b1;
            end else if (sclk_rise) begin
               do_rx = 1'b1;
            end else if (sclk_fall) begin
               if (pending_load) do_load  = 1'b1;
               else              do_shift = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_shift     <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         tx_shift     <= '0;
         tx_underrun  <= 1'b0;
         frame_abort  <= 1'b0;
         bit_cnt      <= '0;
         pending_load <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_abort <= 1'b0;
         if (do_rx) begin
            rx_shift <= {rx_shift[DATA_WIDTH-3:0], mosi_s};
            if (bit_cnt == CNT_LAST) begin
               rx_data      <= {rx_shift, mosi_s};
               rx_valid     <= 1'b1;
               bit_cnt      <= '0;
               pending_load <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
         end
         if (do_load) begin
            tx_shift     <= buf_full ? buf_data : '0;
            tx_underrun  <= ~buf_full;
            bit_cnt      <= '0;
            pending_load <= 1'b0;
         end else if (do_shift) begin
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
         end
         if (do_end) begin
            frame_abort  <= (bit_cnt != '0);
            bit_cnt      <= '0;
            pending_load <= 1'b0;
            tx_shift     <= '0;
         end
      end
   end

   // A load from an empty buffer underruns, but a word accepted that same cycle is kept.
   assign accept = tx_valid & ~buf_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_data <= '0;
         buf_full <= 1'b0;
      end else begin
         if (accept) buf_data <= tx_data;
         buf_full <= do_load ? accept : (buf_full | accept);
      end
   end

   assign tx_ready    = ~buf_full;
   assign spi_miso    = (state_q == ST_ACTIVE) & tx_shift[DATA_WIDTH-1];
   assign spi_miso_oe = ~ss_s;
   assign busy        = ~ss_s;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench: drives a clk/8 mode-0 master and checks the responder against hand-computed words.
module tb_spi_slave_responder;

   localparam int W = 16;
   localparam int S = 2;

   logic clk = 1'b0;
   logic rst_n, spi_sclk, spi_mosi, spi_ss_n, spi_miso, spi_miso_oe;
   logic [W-1:0] tx_data, rx_data;
   logic tx_valid, tx_ready, rx_valid, tx_underrun, frame_abort, busy;

   spi_slave_responder #(.DATA_WIDTH(W), .SYNC_STAGES(S)) dut (
      .clk (clk), .rst_n (rst_n),
      .spi_sclk (spi_sclk), .spi_mosi (spi_mosi), .spi_ss_n (spi_ss_n),
      .spi_miso (spi_miso), .spi_miso_oe (spi_miso_oe),
      .tx_data (tx_data), .tx_valid (tx_valid), .tx_ready (tx_ready),
      .rx_data (rx_data), .rx_valid (rx_valid),
      .tx_underrun (tx_underrun), .frame_abort (frame_abort), .busy (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int rx_total = 0, ur_total = 0, ab_total = 0;
   logic [W-1:0] rx_log [16];
   logic [W-1:0] mosi_q [4];
   logic [W-1:0] miso_q [4];

   always @(negedge clk) begin
      if (rx_valid) begin
         rx_log[rx_total % 16] = rx_data;
         rx_total++;
      end
      if (tx_underrun) ur_total++;
      if (frame_abort) ab_total++;
   end

   task automatic push(input logic [W-1:0] w);
      @(posedge clk); #1;
      tx_valid = 1'b1; tx_data = w;
      @(posedge clk); #1;
      tx_valid = 1'b0;
   endtask

   // One SPI bit: data set up while sclk low, MISO sampled at the rising edge.
   task automatic bit_xfer(input logic m, input logic last, output logic s);
      spi_mosi = m;
      repeat (4) @(posedge clk); #1;
      spi_sclk = 1'b1;
      s = spi_miso;
      repeat (4) @(posedge clk); #1;
      spi_sclk = 1'b0;
      if (last) spi_ss_n = 1'b1;
   endtask

   task automatic frame(input int nbits, input logic inj, input logic [W-1:0] injw);
      logic s;
      for (int k = 0; k < 4; k++) miso_q[k] = '0;
      @(posedge clk); #1;
      spi_ss_n = 1'b0;
      if (inj) begin
         repeat (S) @(posedge clk); #1;
         tx_valid = 1'b1; tx_data = injw;
         @(posedge clk); #1;
         tx_valid = 1'b0;
      end
      for (int i = 0; i < nbits; i++) begin
         bit_xfer(mosi_q[i/16][15-(i%16)], (i == nbits-1), s);
         miso_q[i/16][15-(i%16)] = s;
      end
      repeat (8) @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b1;
      tx_valid = 1'b0; tx_data = '0;
      repeat (3) @(posedge clk); #1;
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
      checks++; if (rx_data !== 16'h0000) begin errors++; $display("FAIL reset_rx_data: got %h expected 0000", rx_data); end
      checks++;
      if ({rx_valid, tx_underrun, frame_abort, busy, spi_miso, spi_miso_oe} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 000000",
                  {rx_valid, tx_underrun, frame_abort, busy, spi_miso, spi_miso_oe});
      end
      rst_n = 1'b1;
      repeat (3) @(posedge clk); #1;
   endtask

   task automatic test_single;
      int rx0, ur0;
      rx0 = rx_total; ur0 = ur_total;
      push(16'hA55A);
      checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL single_ready_low: got %b expected 0", tx_ready); end
      mosi_q[0] = 16'h1234;
      frame(16, 1'b0, '0);
      checks++; if (miso_q[0] !== 16'hA55A) begin errors++; $display("FAIL single_miso: got %h expected a55a", miso_q[0]); end
      checks++; if (rx_total - rx0 !== 1) begin errors++; $display("FAIL single_rx_count: got %0d expected 1", rx_total - rx0); end
      checks++; if (rx_data !== 16'h1234) begin errors++; $display("FAIL single_rx_data: got %h expected 1234", rx_data); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL single_ready_back: got %b expected 1", tx_ready); end
      checks++; if (ur_total - ur0 !== 0) begin errors++; $display("FAIL single_underrun: got %0d expected 0", ur_total - ur0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back;
      int rx0, ur0;
      rx0 = rx_total; ur0 = ur_total;
      push(16'h0001);
      mosi_q[0] = 16'hBEEF; mosi_q[1] = 16'hCAFE;
      fork
         frame(32, 1'b0, '0);
         begin repeat (10) @(posedge clk); push(16'h0002); end
      join
      checks++; if (miso_q[0] !== 16'h0001) begin errors++; $display("FAIL b2b_miso0: got %h expected 0001", miso_q[0]); end
      checks++; if (miso_q[1] !== 16'h0002) begin errors++; $display("FAIL b2b_miso1: got %h expected 0002", miso_q[1]); end
      checks++; if (rx_total - rx0 !== 2) begin errors++; $display("FAIL b2b_rx_count: got %0d expected 2", rx_total - rx0); end
      checks++; if (rx_log[rx0 % 16] !== 16'hBEEF) begin errors++; $display("FAIL b2b_rx0: got %h expected beef", rx_log[rx0 % 16]); end
      checks++; if (rx_log[(rx0+1) % 16] !== 16'hCAFE) begin errors++; $display("FAIL b2b_rx1: got %h expected cafe", rx_log[(rx0+1) % 16]); end
      checks++; if (ur_total - ur0 !== 0) begin errors++; $display("FAIL b2b_underrun: got %0d expected 0", ur_total - ur0); end
   endtask

   task automatic test_underrun;
      int rx0, ur0;
      rx0 = rx_total; ur0 = ur_total;
      mosi_q[0] = 16'h1357; mosi_q[1] = 16'h2468;
      frame(32, 1'b0, '0);
      checks++; if ({miso_q[0], miso_q[1]} !== 32'h0) begin errors++; $display("FAIL ur_miso: got %h%h expected 00000000", miso_q[0], miso_q[1]); end
      checks++; if (ur_total - ur0 !== 2) begin errors++; $display("FAIL ur_count: got %0d expected 2", ur_total - ur0); end
      checks++; if (rx_total - rx0 !== 2) begin errors++; $display("FAIL ur_rx_count: got %0d expected 2", rx_total - rx0); end
      checks++; if (rx_log[rx0 % 16] !== 16'h1357) begin errors++; $display("FAIL ur_rx0: got %h expected 1357", rx_log[rx0 % 16]); end
      checks++; if (rx_log[(rx0+1) % 16] !== 16'h2468) begin errors++; $display("FAIL ur_rx1: got %h expected 2468", rx_log[(rx0+1) % 16]); end
   endtask

   task automatic test_abort;
      int rx0, ab0;
      rx0 = rx_total; ab0 = ab_total;
      mosi_q[0] = 16'hFFFF;
      frame(7, 1'b0, '0);
      checks++; if (ab_total - ab0 !== 1) begin errors++; $display("FAIL abort_count: got %0d expected 1", ab_total - ab0); end
      checks++; if (rx_total - rx0 !== 0) begin errors++; $display("FAIL abort_rx_count: got %0d expected 0", rx_total - rx0); end
      checks++; if (rx_data !== 16'h2468) begin errors++; $display("FAIL abort_rx_held: got %h expected 2468", rx_data); end
      rx0 = rx_total; ab0 = ab_total;
      mosi_q[0] = 16'h0F0F;
      frame(16, 1'b0, '0);
      checks++; if (rx_total - rx0 !== 1) begin errors++; $display("FAIL abort_next_count: got %0d expected 1", rx_total - rx0); end
      checks++; if (rx_data !== 16'h0F0F) begin errors++; $display("FAIL abort_next_data: got %h expected 0f0f", rx_data); end
      checks++; if (ab_total - ab0 !== 0) begin errors++; $display("FAIL abort_next_clean: got %0d expected 0", ab_total - ab0); end
   endtask

   task automatic test_simul_accept_load;
      int ur0;
      ur0 = ur_total;
      mosi_q[0] = 16'h1111; mosi_q[1] = 16'h2222;
      frame(32, 1'b1, 16'h5555);
      checks++; if (miso_q[0] !== 16'h0000) begin errors++; $display("FAIL simul_miso0: got %h expected 0000", miso_q[0]); end
      checks++; if (miso_q[1] !== 16'h5555) begin errors++; $display("FAIL simul_miso1: got %h expected 5555", miso_q[1]); end
      checks++; if (ur_total - ur0 !== 1) begin errors++; $display("FAIL simul_underrun: got %0d expected 1", ur_total - ur0); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL simul_ready: got %b expected 1", tx_ready); end
   endtask

   task automatic test_reset_mid_frame;
      logic s;
      int rx0, ab0;
      mosi_q[0] = 16'hAAAA;
      @(posedge clk); #1;
      spi_ss_n = 1'b0;
      for (int i = 0; i < 9; i++) bit_xfer(mosi_q[0][15-i], 1'b0, s);
      checks++; if ({busy, spi_miso_oe} !== 2'b11) begin errors++; $display("FAIL mid_busy: got %b expected 11", {busy, spi_miso_oe}); end
      rst_n = 1'b0;
      #1;
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", tx_ready); end
      checks++; if (rx_data !== 16'h0000) begin errors++; $display("FAIL mid_rst_rx_data: got %h expected 0000", rx_data); end
      checks++;
      if ({rx_valid, tx_underrun, frame_abort, busy, spi_miso, spi_miso_oe} !== 6'b0) begin
         errors++;
         $display("FAIL mid_rst_outputs: got %b expected 000000",
                  {rx_valid, tx_underrun, frame_abort, busy, spi_miso, spi_miso_oe});
      end
      spi_ss_n = 1'b1;
      repeat (3) @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk); #1;
      rx0 = rx_total; ab0 = ab_total;
      mosi_q[0] = 16'h00FF;
      frame(16, 1'b0, '0);
      checks++; if (rx_data !== 16'h00FF) begin errors++; $display("FAIL mid_after_data: got %h expected 00ff", rx_data); end
      checks++; if (rx_total - rx0 !== 1) begin errors++; $display("FAIL mid_after_count: got %0d expected 1", rx_total - rx0); end
      checks++; if (ab_total - ab0 !== 0) begin errors++; $display("FAIL mid_after_abort: got %0d expected 0", ab_total - ab0); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_simul_accept_load();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
